// File: rtl/hazard_control_unit_pkg.sv
// ============================================================================
// Module  : hazard_control_unit_pkg
// Purpose : Shared encodings for the hazard control unit (state, freeze limit).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_control_unit_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } hcu_state_t;

  localparam logic [7:0] FREEZE_LIMIT_DEFAULT = 8'd255;
  localparam logic [7:0] FREEZE_CNT_MAX       = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == FREEZE_CNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_load_use_detect.sv
// ============================================================================
// Module  : load_use_detect
// Purpose : Flags an ID-stage source that depends on a load still in EX.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect (
  input  logic       exe_mem_read,
  input  logic [4:0] exe_addr,
  input  logic [4:0] id_addr1,
  input  logic [4:0] id_addr2,
  input  logic       id_uses1,
  input  logic       id_uses2,
  output logic       load_use
);

  logic match1;
  logic match2;

  always_comb begin
    match1   = id_uses1 && (id_addr1 == exe_addr);
    match2   = id_uses2 && (id_addr2 == exe_addr);
    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    load_use = exe_mem_read && (exe_addr != 5'd0) && (match1 || match2);
  end

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module  : hazard_control_unit
// Purpose : Pipeline stall/flush/freeze control with a sticky freeze timeout.
//           Optional macro HAZARD_PERF_COUNT_EN adds stall/flush counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter logic [7:0] FREEZE_LIMIT = FREEZE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  exe_addr,
  input  logic        exe_mem_read,
  input  logic [4:0]  id_addr1,
  input  logic [4:0]  id_addr2,
  input  logic        id_uses1,
  input  logic        id_uses2,
  input  logic        branch_taken,
  input  logic        dmem_busy,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        id_ex_write_en,
  output logic        ex_mem_write_en,
  output logic        mem_wb_write_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
`ifdef HAZARD_PERF_COUNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        mem_timeout
);

  hcu_state_t state_q, state_d;
  logic       flush_pend_q, flush_pend_d;
  logic [7:0] freeze_cnt_q, freeze_cnt_d;
  logic       timeout_q, timeout_d;
  logic       load_use;

  load_use_detect u_load_use_detect (
    .exe_mem_read (exe_mem_read),
    .exe_addr     (exe_addr),
    .id_addr1     (id_addr1),
    .id_addr2     (id_addr2),
    .id_uses1     (id_uses1),
    .id_uses2     (id_uses2),
    .load_use     (load_use)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      freeze_cnt_q <= 8'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      freeze_cnt_q <= freeze_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_pend_d    = flush_pend_q;
    freeze_cnt_d    = freeze_cnt_q;
    timeout_d       = timeout_q;
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    mem_wb_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;

    if (!reset) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
    end else if (dmem_busy) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_write_en = 1'b0;
      state_d         = FREEZE;
      // A branch resolved during a freeze must survive until the pipe moves
      flush_pend_d    = flush_pend_q | branch_taken;
      freeze_cnt_d    = (state_q == RUN) ? 8'd1 : sat_inc8(freeze_cnt_q);
      if (freeze_cnt_d >= FREEZE_LIMIT) begin
        timeout_d = 1'b1;
      end
    end else begin
      state_d      = RUN;
      flush_pend_d = 1'b0;
      freeze_cnt_d = 8'd0;
      if (branch_taken || flush_pend_q) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_flush    = 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_COUNT_EN
  logic        frozen_cycle;
  logic        flush_applied;
  logic        load_use_stall;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  assign frozen_cycle   = reset && dmem_busy;
  assign flush_applied  = reset && !dmem_busy && (branch_taken || flush_pend_q);
  assign load_use_stall = reset && !dmem_busy && !(branch_taken || flush_pend_q) && load_use;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (frozen_cycle || load_use_stall) begin
        stall_q <= stall_q + 32'd1;
      end
      if (flush_applied) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module  : tb_hazard_control_unit
// Purpose : Randomized + directed self-checking bench against a rule-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

  localparam logic [7:0] LIMIT = 8'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] exe_addr = '0;
  logic       exe_mem_read = 1'b0;
  logic [4:0] id_addr1 = '0;
  logic [4:0] id_addr2 = '0;
  logic       id_uses1 = 1'b0;
  logic       id_uses2 = 1'b0;
  logic       branch_taken = 1'b0;
  logic       dmem_busy = 1'b0;
  logic       pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
  logic       if_id_flush, id_ex_flush, mem_timeout;
`ifdef HAZARD_PERF_COUNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  logic [6:0] outs;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  // model state: values the DUT registers should hold after the coming edge
  bit     m_known = 1'b0;
  bit     m_pend = 1'b0;
  int     m_frz = 0;
  bit     m_timeout = 1'b0;
  longint m_stall = 0;
  longint m_flush = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.FREEZE_LIMIT(LIMIT)) dut (
    .clk             (clk),
    .reset           (reset),
    .exe_addr        (exe_addr),
    .exe_mem_read    (exe_mem_read),
    .id_addr1        (id_addr1),
    .id_addr2        (id_addr2),
    .id_uses1        (id_uses1),
    .id_uses2        (id_uses2),
    .branch_taken    (branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .id_ex_write_en  (id_ex_write_en),
    .ex_mem_write_en (ex_mem_write_en),
    .mem_wb_write_en (mem_wb_write_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
`ifdef HAZARD_PERF_COUNT_EN
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
`endif
    .mem_timeout     (mem_timeout)
  );

  assign outs = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
                 mem_wb_write_en, if_id_flush, id_ex_flush};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model compare: outputs derived from the priority rules, checked every cycle
  always @(negedge clk) begin
    if (!done) begin
      bit         hazard;
      logic [6:0] exp;
      hazard = exe_mem_read && (exe_addr != 0) &&
               ((id_uses1 && id_addr1 == exe_addr) || (id_uses2 && id_addr2 == exe_addr));
      if (!reset)                        exp = 7'b0000011;
      else if (dmem_busy)                exp = 7'b0000000;
      else if (branch_taken || m_pend)   exp = 7'b1111111;
      else if (hazard)                   exp = 7'b0011101;
      else                               exp = 7'b1111100;
      chk("model_outs", {25'd0, outs}, {25'd0, exp});
      if (m_known) begin
        chk("model_timeout", {31'd0, mem_timeout}, {31'd0, m_timeout});
`ifdef HAZARD_PERF_COUNT_EN
        chk("model_stall", stall_cycles, m_stall[31:0]);
        chk("model_flush", flush_count, m_flush[31:0]);
`endif
      end
      if (!reset) begin
        m_known = 1'b1; m_pend = 1'b0; m_frz = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
      end else if (dmem_busy) begin
        m_pend = m_pend || branch_taken;
        m_frz++;
        m_stall++;
        if (m_frz >= int'(LIMIT)) m_timeout = 1'b1;
      end else begin
        m_frz = 0;
        if (branch_taken || m_pend) begin
          m_pend = 1'b0;
          m_flush++;
        end else if (hazard) begin
          m_stall++;
        end
      end
    end
  end

  task automatic step(input logic r, input logic b, input logic br, input logic mr,
                      input logic [4:0] ea, input logic [4:0] a1, input logic u1,
                      input logic [4:0] a2, input logic u2);
    @(posedge clk);
    #1;
    reset = r; dmem_busy = b; branch_taken = br; exe_mem_read = mr;
    exe_addr = ea; id_addr1 = a1; id_uses1 = u1; id_addr2 = a2; id_uses2 = u2;
    #1;
  endtask

  initial begin
    int burst;
    // reset behaviour
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_outs", {25'd0, outs}, 32'h03);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("idle_outs", {25'd0, outs}, 32'h7C);
    // load-use stall, then the load leaves EX
    step(1, 0, 0, 1, 5'd1, 5'd7, 0, 5'd1, 1);
    chk("load_use_stall", {25'd0, outs}, 32'h1D);
    step(1, 0, 0, 0, 5'd3, 5'd7, 0, 5'd1, 1);
    chk("load_use_once", {25'd0, outs}, 32'h7C);
    // x0 never hazards
    step(1, 0, 0, 1, 5'd0, 5'd0, 1, 5'd9, 0);
    chk("x0_no_stall", {25'd0, outs}, 32'h7C);
    // branch beats load-use
    step(1, 0, 1, 1, 5'd2, 5'd2, 1, 5'd0, 0);
    chk("branch_over_lu", {25'd0, outs}, 32'h7F);
    // freeze with branch in 2nd cycle -> deferred flush
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("freeze_c1", {25'd0, outs}, 32'h00);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("freeze_c2", {25'd0, outs}, 32'h00);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("freeze_c3", {25'd0, outs}, 32'h00);
    step(1, 0, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0);
    chk("pend_flush", {25'd0, outs}, 32'h7F);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("after_flush", {25'd0, outs}, 32'h7C);
`ifdef HAZARD_PERF_COUNT_EN
    chk("perf_stall_3", stall_cycles, 32'd3);
    chk("perf_flush_1", flush_count, 32'd1);
`endif
    // timeout: limit 4, six frozen cycles
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("timeout_hold", {31'd0, mem_timeout}, (i >= 4) ? 32'd1 : 32'd0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    chk("resume_outs", {25'd0, outs}, 32'h7C);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout_cleared", {31'd0, mem_timeout}, 32'd0);
    // randomized traffic with busy bursts and occasional reset
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      logic b;
      if (burst == 0 && $urandom_range(99) < 12) burst = $urandom_range(8, 1);
      b = (burst != 0);
      if (burst != 0) burst--;
      step(($urandom_range(99) < 2) ? 1'b0 : 1'b1, b, ($urandom_range(99) < 12),
           $urandom_range(1), 5'($urandom_range(3)), 5'($urandom_range(3)),
           $urandom_range(1), 5'($urandom_range(3)), $urandom_range(1));
    end
    @(posedge clk);
    #1;
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
